// File: rtl/sweep_pkg.sv
// Shared definitions for the frequency-sweep controller.
package sweep_pkg;

    localparam int PW_DEF = 16;
    localparam int CW_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sweep_next_inc.sv
// Combinational next-increment stepper: moves cur one step toward stop,
// clamped so it never overshoots stop or wraps.
module sweep_next_inc #(
    parameter int PW = 16
) (
    input  logic [PW-1:0] cur_i,
    input  logic [PW-1:0] stop_i,
    input  logic [PW-1:0] step_i,
    output logic [PW-1:0] nxt_o,
    output logic          at_stop_o
);

    logic [PW:0] gap;
    logic [PW:0] step_ext;

    always_comb begin
        step_ext  = {1'b0, step_i};
        gap       = '0;
        nxt_o     = stop_i;
        at_stop_o = (cur_i == stop_i);
        if (stop_i > cur_i) begin
            gap = {1'b0, stop_i} - {1'b0, cur_i};
            // a zero step jumps straight to stop so the sweep cannot stall
            if (step_i != '0 && gap > step_ext) begin
                nxt_o = cur_i + step_i;
            end
        end else if (cur_i > stop_i) begin
            gap = {1'b0, cur_i} - {1'b0, stop_i};
            if (step_i != '0 && gap > step_ext) begin
                nxt_o = cur_i - step_i;
            end
        end
    end

endmodule

// File: rtl/sweep_ctrl.sv
// Stepped-frequency sweep controller driving the sine generator phasein.
// state   | meaning
// ST_IDLE | no sweep; phasein holds last value
// ST_RUN  | sweep in progress; each increment held for max(dwell,1) cycles
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          loop,
    input  logic [PW-1:0] f_start,
    input  logic [PW-1:0] f_stop,
    input  logic [PW-1:0] f_step,
    input  logic [CW-1:0] dwell,
    output logic [PW-1:0] phasein,
    output logic          busy,
    output logic          done
);

    state_t        state_q,   state_d;
    logic [PW-1:0] phasein_q, phasein_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;
    logic [PW-1:0] fstart_q,  fstart_d;
    logic [PW-1:0] fstop_q,   fstop_d;
    logic [PW-1:0] fstep_q,   fstep_d;
    logic [CW-1:0] dwell_q,   dwell_d;
    logic          loop_q,    loop_d;

    logic [PW-1:0] nxt_inc;
    logic          at_stop;

    function automatic logic [CW-1:0] reload(input logic [CW-1:0] d);
        return (d == '0) ? '0 : d - CW'(1);
    endfunction

    sweep_next_inc #(.PW(PW)) u_next (
        .cur_i     (phasein_q),
        .stop_i    (fstop_q),
        .step_i    (fstep_q),
        .nxt_o     (nxt_inc),
        .at_stop_o (at_stop)
    );

    always_comb begin
        state_d   = state_q;
        phasein_d = phasein_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        fstart_d  = fstart_q;
        fstop_d   = fstop_q;
        fstep_d   = fstep_q;
        dwell_d   = dwell_q;
        loop_d    = loop_q;
        if (abort) begin
            state_d   = ST_IDLE;
            phasein_d = '0;
            cnt_d     = '0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        fstart_d  = f_start;
                        fstop_d   = f_stop;
                        fstep_d   = f_step;
                        dwell_d   = dwell;
                        loop_d    = loop;
                        phasein_d = f_start;
                        cnt_d     = reload(dwell);
                        busy_d    = 1'b1;
                        state_d   = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (!at_stop) begin
                        phasein_d = nxt_inc;
                        cnt_d     = reload(dwell_q);
                    end else begin
                        done_d = 1'b1;
                        if (loop_q) begin
                            phasein_d = fstart_q;
                            cnt_d     = reload(dwell_q);
                        end else begin
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            phasein_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fstart_q  <= '0;
            fstop_q   <= '0;
            fstep_q   <= '0;
            dwell_q   <= '0;
            loop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phasein_q <= phasein_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fstart_q  <= fstart_d;
            fstop_q   <= fstop_d;
            fstep_q   <= fstep_d;
            dwell_q   <= dwell_d;
            loop_q    <= loop_d;
        end
    end

    assign phasein = phasein_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl: directed plan cases plus random sweeps
// compared against a per-cycle expected trace built from the sweep rules.
module tb_sweep_ctrl;

    logic        clock;
    logic        reset;
    logic        start;
    logic        abort;
    logic        loop;
    logic [15:0] f_start;
    logic [15:0] f_stop;
    logic [15:0] f_step;
    logic [15:0] dwell;
    logic [15:0] phasein;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    sweep_ctrl #(.PW(16), .CW(16)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .loop    (loop),
        .f_start (f_start),
        .f_stop  (f_stop),
        .f_step  (f_step),
        .dwell   (dwell),
        .phasein (phasein),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int ep, input int eb, input int ed);
        chk({tag, "/phasein"}, {16'h0, phasein}, ep);
        chk({tag, "/busy"},    {31'h0, busy},    eb);
        chk({tag, "/done"},    {31'h0, done},    ed);
    endtask

    // One clamped step toward the target, in plain integer arithmetic.
    function automatic int step_toward(input int v, input int fe, input int st);
        if (v == fe) return v;
        if (fe > v) return (st == 0 || fe - v <= st) ? fe : v + st;
        return (st == 0 || v - fe <= st) ? fe : v - st;
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Starts a sweep and checks every cycle; loop sweeps end with an abort.
    task automatic sweep(input string tag, input int fs, input int fe, input int st,
                         input int dw, input bit lp, input int n_loop, input bit repulse);
        int vals[$];
        int d, v, n_run, ep, eb, ed, idx;
        d = (dw == 0) ? 1 : dw;
        v = fs;
        forever begin
            repeat (d) vals.push_back(v);
            if (v == fe) break;
            v = step_toward(v, fe, st);
        end
        f_start = 16'(fs);
        f_stop  = 16'(fe);
        f_step  = 16'(st);
        dwell   = 16'(dw);
        loop    = lp;
        start   = 1'b1;
        next_cycle();
        start   = 1'b0;
        f_start = 16'($urandom);
        f_stop  = 16'($urandom);
        f_step  = 16'($urandom);
        dwell   = 16'($urandom);
        loop    = 1'($urandom);
        n_run = lp ? n_loop : vals.size() + 2;
        for (int i = 1; i <= n_run; i++) begin
            if (lp) begin
                idx = (i - 1) % vals.size();
                ep = vals[idx];
                eb = 1;
                ed = (i > 1 && idx == 0) ? 1 : 0;
            end else if (i <= vals.size()) begin
                ep = vals[i-1];
                eb = 1;
                ed = 0;
            end else begin
                ep = fe;
                eb = 0;
                ed = (i == vals.size() + 1) ? 1 : 0;
            end
            chk_out(tag, ep, eb, ed);
            start = repulse && (i == 1);
            if (lp && i == n_run) abort = 1'b1;
            next_cycle();
        end
        start = 1'b0;
        if (lp) begin
            abort = 1'b0;
            chk_out({tag, "/abort"}, 0, 0, 0);
        end
    endtask

    initial begin
        int fs, fe, delta;
        reset   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        loop    = 1'b0;
        f_start = '0;
        f_stop  = '0;
        f_step  = '0;
        dwell   = '0;
        #1;
        chk_out("reset", 0, 0, 0);
        #12 reset = 1'b1;
        next_cycle();
        chk_out("idle_after_reset", 0, 0, 0);

        sweep("up",        100,   130,   10,   4, 1'b0, 0, 1'b0);
        sweep("down",      1000,  975,   10,   1, 1'b0, 0, 1'b0);
        sweep("ovf",       'hFFF0, 'hFFFF, 'h20, 2, 1'b0, 0, 1'b0);
        sweep("loop",      10,    30,    10,   1, 1'b1, 11, 1'b0);
        sweep("dwell0",    200,   170,   15,   0, 1'b0, 0, 1'b0);
        sweep("step0",     5,     50,    0,    1, 1'b0, 0, 1'b0);
        sweep("same",      77,    77,    3,    3, 1'b0, 0, 1'b0);
        sweep("repulse",   40,    70,    10,   2, 1'b0, 0, 1'b1);

        // abort beats start while idle
        f_start = 16'd300;
        f_stop  = 16'd400;
        f_step  = 16'd10;
        dwell   = 16'd1;
        start   = 1'b1;
        abort   = 1'b1;
        next_cycle();
        start   = 1'b0;
        abort   = 1'b0;
        chk_out("start_abort", 0, 0, 0);
        next_cycle();
        chk_out("start_abort_hold", 0, 0, 0);

        // asynchronous reset between clock edges
        f_start = 16'd100;
        f_stop  = 16'd130;
        f_step  = 16'd10;
        dwell   = 16'd4;
        start   = 1'b1;
        next_cycle();
        start   = 1'b0;
        repeat (5) next_cycle();
        chk_out("pre_reset", 110, 1, 0);
        #2 reset = 1'b0;
        #1;
        chk_out("async_reset", 0, 0, 0);
        #3 reset = 1'b1;
        repeat (3) next_cycle();
        chk_out("post_reset_idle", 0, 0, 0);

        for (int k = 0; k < 12; k++) begin
            fs = int'($urandom_range(0, 65535));
            delta = int'($urandom_range(0, 150));
            if ($urandom_range(0, 1) == 1) fe = (fs + delta > 65535) ? 65535 : fs + delta;
            else fe = (fs - delta < 0) ? 0 : fs - delta;
            sweep("rand", fs, fe, int'($urandom_range(0, 30)), int'($urandom_range(0, 3)),
                  (k % 4 == 3), int'($urandom_range(5, 40)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sweep_ctrl.md
Name: sweep_ctrl

Overview:
Frequency-sweep controller that drives the phase-increment input (phasein) of the testbench sine generator. It steps phasein from a start to a stop increment, in fixed increments, with a programmable dwell time per step. Single-shot and loop modes are supported. The FIR testbench uses it to produce stepped-frequency stimulus for magnitude-response measurement.

Parameters:
PW, 16, width of phase increment values (matches the sine generator's phasein input).
CW, 16, width of the dwell counter.

Ports:
clock  input  1  system clock; the same clock as the sine generator.
reset  input  1  reset; asynchronous, active-low.
start  input  1  single-cycle request to begin a sweep; sampled only in IDLE.
abort  input  1  terminates a sweep immediately; has priority over start.
loop  input  1  1 = restart from f_start after reaching f_stop; sampled at start.
f_start  input  PW  first phase increment.
f_stop  input  PW  final phase increment; may be above or below f_start.
f_step  input  PW  step magnitude (unsigned).
dwell  input  CW  clock cycles each increment is held.
phasein  output  PW  phase increment to the sine generator; registered.
busy  output  1  high while a sweep is in progress.
done  output  1  one-cycle pulse at the end of each completed sweep.

Behaviour:
- One clock; reset is asynchronous and active-low. Reset values: phasein=0, busy=0, done=0, state=IDLE, dwell counter=0.
- States:
  - IDLE: busy=0; phasein holds its last value.
  - RUN: busy=1.
- Transitions:
  - IDLE -> RUN: start=1 and abort=0. At that edge:
    - latch f_start, f_stop, f_step, dwell, loop into internal registers;
    - phasein<=f_start; counter<=max(dwell,1)-1.
    - phasein shows f_start in the cycle after start.
  - RUN each cycle, counter>0: counter decrements; phasein is held.
  - RUN, counter==0 and phasein!=stop_l: phasein moves one step toward stop_l, with clamping:
    - up sweep (stop_l>phasein): if stop_l-phasein<=step_l, then stop_l, else phasein+step_l;
    - down sweep: the mirror of the up rule;
    - compute in PW+1 bits; phasein never wraps and never overshoots stop_l;
    - counter reloads to max(dwell_l,1)-1.
  - RUN, counter==0 and phasein==stop_l:
    - done=1 for exactly one cycle;
    - loop_l=1: phasein<=start_l, counter reloads, stay in RUN;
    - loop_l=0: go to IDLE, busy<=0 on the same edge, phasein holds stop_l.
  - abort=1 in any state: next edge gives IDLE, phasein<=0, busy<=0, done=0 (no done pulse).
- Dwell and step rules:
  - Every phasein value, including f_stop, is held for exactly max(dwell,1) cycles.
  - Total single-shot sweep length = (N+1)*max(dwell,1) cycles, where N=ceil(|stop-start|/step).
- Degenerate and simultaneous cases:
  - f_step=0: the first step jumps directly to stop_l, which prevents a hang.
  - f_start==f_stop: one dwell period, then done.
  - start while busy: ignored.
  - start and abort in the same cycle: abort wins.
  - Config inputs changing during RUN: no effect.
- done and busy are registered outputs; there are no combinational input-to-output paths.

Decomposition:
- Shared package sweep_pkg:
  - state encoding localparams (ST_IDLE, ST_RUN);
  - default widths PW_DEF=16, CW_DEF=16.
- One natural sub-module, sweep_next_inc: purely combinational. It takes the current increment, stop_l and step_l, and returns the clamped next increment plus an at_stop flag. It is unit-testable in isolation.
- The dwell counter and FSM stay in sweep_ctrl.

Test Plan:
- Up sweep: f_start=100, f_stop=130, f_step=10, dwell=4, loop=0, start pulse at edge 0 -> phasein=100 for cycles 1-4, 110 for 5-8, 120 for 9-12, 130 for 13-16; done=1 in cycle 17 only; busy falls in cycle 17; phasein stays 130.
- Down sweep with clamp: f_start=1000, f_stop=975, f_step=10, dwell=1 -> phasein sequence 1000, 990, 980, 975, then done; no value below 975 is ever produced.
- Overflow guard: f_start=16'hFFF0, f_stop=16'hFFFF, f_step=16'h0020, dwell=2 -> phasein FFF0, FFF0, FFFF, FFFF, then done; never wraps to 0x000F.
- Loop and abort: f_start=10, f_stop=30, f_step=10, dwell=1, loop=1 -> sequence 10, 20, 30, 10, 20, ...; done pulses on every return to 10. Then abort mid-sweep -> next cycle phasein=0, busy=0, no done pulse.
- Degenerate inputs:
  - dwell=0 behaves as dwell=1;
  - f_step=0 with start=5, stop=50 -> 5 then 50, then done;
  - start re-pulsed while busy -> sequence unchanged;
  - start and abort in the same cycle -> remains IDLE.
- Async reset: assert reset low mid-sweep between clock edges -> phasein=0, busy=0, done=0 immediately; after release, idle until the next start.
